// File: rtl/cnt_arb.sv
// cnt_arb: one shared modulo counter time-shared among NREQ requesters.
// Define CNT_ARB_PRIO_EN for fixed-priority arbitration instead of round-robin.
module cnt_arb #(
  parameter int NREQ = 4,
  parameter int W    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] ceil_i,
  input  logic [2:0]        reps,
  output logic [NREQ-1:0]   gnt,
  output logic [W-1:0]      cnt,
  output logic              co,
  output logic [NREQ-1:0]   done,
  output logic              busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [NREQ-1:0] r_gnt;
  logic [NREQ-1:0] w_gnt_nxt;
  logic [W-1:0]    r_cnt;
  logic [W-1:0]    w_cnt_nxt;
  logic [W-1:0]    r_ceil;
  logic [W-1:0]    w_ceil_nxt;
  logic [2:0]      r_per;
  logic [2:0]      w_per_nxt;
  logic [2:0]      r_reps;
  logic [2:0]      w_reps_nxt;

  logic [PW-1:0]   w_win;
  logic            w_any;
  logic            w_tc;
  logic            w_abort;
  logic            w_s_idle;
  logic            w_s_run;
  logic            w_s_done;

`ifndef CNT_ARB_PRIO_EN
  logic [PW-1:0]   r_ptr;
  logic [PW-1:0]   w_ptr_nxt;
`endif

  // Winner select; scanning downward leaves the closest match last.
`ifdef CNT_ARB_PRIO_EN
  always_comb begin
    w_win = '0;
    w_any = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        w_win = PW'(i);
        w_any = 1'b1;
      end
    end
  end
`else
  always_comb begin
    w_win = '0;
    w_any = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[(int'(r_ptr) + i) % NREQ]) begin
        w_win = PW'((int'(r_ptr) + i) % NREQ);
        w_any = 1'b1;
      end
    end
  end
`endif

  assign w_s_idle = (r_state == S_IDLE);
  assign w_s_run  = (r_state == S_RUN);
  assign w_s_done = (r_state == S_DONE);

  assign w_tc    = (r_cnt == r_ceil);
  assign w_abort = ~|(req & r_gnt);

  assign gnt  = r_gnt;
  assign cnt  = r_cnt;
  assign co   = w_s_run & w_tc;
  assign done = w_s_done ? r_gnt : '0;
  assign busy = w_s_run | w_s_done;

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_cnt_nxt   = r_cnt;
    w_ceil_nxt  = r_ceil;
    w_per_nxt   = r_per;
    w_reps_nxt  = r_reps;
`ifndef CNT_ARB_PRIO_EN
    w_ptr_nxt   = r_ptr;
`endif
    unique case (1'b1)
      w_s_idle: begin
        w_gnt_nxt = '0;
        w_cnt_nxt = '0;
        if (w_any) begin
          w_state_nxt = S_RUN;
          w_gnt_nxt   = NREQ'(1) << w_win;
          w_per_nxt   = '0;
          w_ceil_nxt  = ceil_i[int'(w_win)*W +: W];
          w_reps_nxt  = reps;
`ifndef CNT_ARB_PRIO_EN
          w_ptr_nxt   = PW'((int'(w_win) + 1) % NREQ);
`endif
        end
      end
      w_s_run: begin
        if (w_abort) begin
          w_state_nxt = S_IDLE;
          w_gnt_nxt   = '0;
          w_cnt_nxt   = '0;
        end else if (w_tc) begin
          w_cnt_nxt = '0;
          if (r_per == r_reps) begin
            w_state_nxt = S_DONE;
          end else begin
            w_per_nxt = r_per + 3'd1;
          end
        end else begin
          w_cnt_nxt = r_cnt + W'(1);
        end
      end
      w_s_done: begin
        w_state_nxt = S_IDLE;
        w_gnt_nxt   = '0;
        w_cnt_nxt   = '0;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_gnt_nxt   = '0;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_gnt   <= '0;
      r_cnt   <= '0;
      r_ceil  <= '0;
      r_per   <= '0;
      r_reps  <= '0;
`ifndef CNT_ARB_PRIO_EN
      r_ptr   <= '0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ceil  <= w_ceil_nxt;
      r_per   <= w_per_nxt;
      r_reps  <= w_reps_nxt;
`ifndef CNT_ARB_PRIO_EN
      r_ptr   <= w_ptr_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_cnt_arb.sv
// tb_cnt_arb: scoreboard bench for cnt_arb against a grant-level model.
// Honours CNT_ARB_PRIO_EN the same way as the design.
`timescale 1ns/1ps
module tb_cnt_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [15:0] ceil_i;
  logic [2:0]  reps;
  logic [3:0]  gnt;
  logic [3:0]  cnt;
  logic        co;
  logic [3:0]  done;
  logic        busy;

  cnt_arb #(.NREQ(4), .W(4)) dut (
    .clk(clk), .rst(rst), .req(req), .ceil_i(ceil_i),
    .reps(reps), .gnt(gnt), .cnt(cnt), .co(co),
    .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] gnt;
    logic [3:0] cnt;
    logic       co;
    logic [3:0] done;
    logic       busy;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_err = 0;
  int   n_chk = 0;

  // Model: phase 0 idle, 1 run (t = RUN cycles elapsed), 2 done.
  int m_phase = 0;
  int m_w     = 0;
  int m_c     = 0;
  int m_r     = 0;
  int m_t     = 0;
  int m_ptr   = 0;

  logic        drv_rst  = 1'b1;
  logic [3:0]  drv_req  = '0;
  logic [15:0] drv_ceil = '0;
  logic [2:0]  drv_reps = '0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [3:0] q);
    int s;
`ifdef CNT_ARB_PRIO_EN
    s = 0;
`else
    s = m_ptr;
`endif
    for (int i = 0; i < 4; i++)
      if (q[(s + i) % 4]) return (s + i) % 4;
    return 0;
  endfunction

  // Advance the model over one edge using the inputs held before it.
  task automatic model_edge();
    if (rst) begin
      m_phase = 0;
      m_ptr   = 0;
    end else if (m_phase == 0) begin
      if (req != 4'd0) begin
        m_w     = pick(req);
        m_ptr   = (m_w + 1) % 4;
        m_c     = int'(ceil_i[m_w*4 +: 4]);
        m_r     = int'(reps);
        m_t     = 0;
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      if (!req[m_w]) begin
        m_phase = 0;
      end else begin
        m_t++;
        if (m_t == (m_c + 1) * (m_r + 1)) m_phase = 2;
      end
    end else begin
      m_phase = 0;
    end
  endtask

  task automatic push_exp();
    exp_t e;
    e = '0;
    if (m_phase == 1) begin
      e.gnt  = 4'(1 << m_w);
      e.cnt  = 4'(m_t % (m_c + 1));
      e.co   = ((m_t % (m_c + 1)) == m_c);
      e.busy = 1'b1;
    end else if (m_phase == 2) begin
      e.gnt  = 4'(1 << m_w);
      e.done = 4'(1 << m_w);
      e.busy = 1'b1;
    end
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    push_exp();
    #1;
    rst    = drv_rst;
    req    = drv_req;
    ceil_i = drv_ceil;
    reps   = drv_reps;
  endtask

  task automatic run_until(input int ph, input int t);
    int n;
    n = 0;
    while (!(m_phase == ph && (t < 0 || m_t == t)) && n < 300) begin
      step();
      n++;
    end
    chk("wait_bound", n < 300, 1);
  endtask

  task automatic do_reset();
    drv_rst  = 1'b1;
    drv_req  = '0;
    drv_ceil = '0;
    drv_reps = '0;
    step();
    drv_rst = 1'b0;
    step();
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        chk("gnt",  int'(gnt),  int'(mon_e.gnt));
        chk("cnt",  int'(cnt),  int'(mon_e.cnt));
        chk("co",   int'(co),   int'(mon_e.co));
        chk("done", int'(done), int'(mon_e.done));
        chk("busy", int'(busy), int'(mon_e.busy));
      end
    end
  end

  initial begin
    rst = 1'b1; req = '0; ceil_i = '0; reps = '0;
    do_reset();

    // Idle quiet period.
    repeat (10) step();

    // Single grant, ceil 2, two periods.
    do_reset();
    drv_req = 4'b0010; drv_ceil = 16'h0020; drv_reps = 3'd1;
    step();
    run_until(2, -1);
    drv_req = '0;
    repeat (3) step();

    // All requesting, ceil 0, one period each.
    do_reset();
    drv_req = 4'hF; drv_ceil = '0; drv_reps = '0;
    repeat (16) step();
    drv_req = '0;
    repeat (2) step();

    // Abort at cnt 3, then 0011 resolves past the aborted one.
    do_reset();
    drv_req = 4'b0001; drv_ceil = 16'h0005;
    step();
    run_until(1, 2);
    drv_req = '0;
    step();
    drv_req = 4'b0011;
    step();
    run_until(2, -1);
    drv_req = '0;
    repeat (2) step();

    // Reset during cnt 4, pointer back to 0.
    do_reset();
    drv_req = 4'b0001; drv_ceil = 16'h0006;
    step();
    run_until(1, 3);
    drv_rst = 1'b1;
    step();
    drv_rst = 1'b0; drv_req = '0;
    step();
    drv_req = 4'hF; drv_ceil = 16'h1111;
    repeat (4) step();
    drv_req = '0;
    repeat (2) step();

    // Latched ceil/reps immune to input changes.
    do_reset();
    drv_req = 4'b0100; drv_ceil = 16'h0300; drv_reps = 3'd7;
    step();
    run_until(1, 0);
    for (int n = 0; n < 60 && m_phase == 1; n++) begin
      drv_ceil = 16'($urandom);
      drv_reps = 3'($urandom);
      step();
    end
    drv_req = '0;
    repeat (2) step();

    // Random traffic.
    do_reset();
    for (int n = 0; n < 2000; n++) begin
      for (int k = 0; k < 4; k++) begin
        if (!drv_req[k]) begin
          if ($urandom_range(0, 3) == 0) drv_req[k] = 1'b1;
        end else if (m_phase == 2 && m_w == k) begin
          drv_req[k] = 1'b0;
        end else if ($urandom_range(0, 49) == 0) begin
          drv_req[k] = 1'b0;
        end
        drv_ceil[k*4 +: 4] = ($urandom_range(0, 9) == 0) ?
          4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
      end
      drv_reps = ($urandom_range(0, 9) == 0) ?
        3'($urandom_range(0, 7)) : 3'($urandom_range(0, 2));
      drv_rst = ($urandom_range(0, 299) == 0);
      step();
    end

    drv_rst = 1'b0; drv_req = '0;
    step();
    @(negedge clk);
    #2;
    chk("sb_drain", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/cnt_arb.md
CNT_ARB -- requirements
Module: cnt_arb

Interface
REQ-001 Parameter NREQ, default 4, number of requesters (fixed 4 in this revision).
REQ-002 Parameter W, default 4, counter and ceiling width in bits.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-005 req  input  NREQ  per-requester level request; held high until done or abort.
REQ-006 ceil_i  input  NREQ*W  flat ceilings; requester k owns bits [k*W+W-1 : k*W].
REQ-007 reps  input  3  periods per grant minus one (0 = one period, 7 = eight periods).
REQ-008 gnt  output  NREQ  one-hot grant, all-zero when no grant.
REQ-009 cnt  output  W  current count of the shared modulo counter.
REQ-010 co  output  1  terminal-count strobe, high while cnt equals the latched ceiling in RUN.
REQ-011 done  output  NREQ  one-cycle completion pulse to the served requester.
REQ-012 busy  output  1  high in RUN or DONE.

Function
REQ-013 The block SHALL time-share one modulo-(ceil+1) counter among NREQ requesters via FSM states IDLE, RUN, DONE.
REQ-014 IDLE: with any req high, select one winner, latch its ceiling into ceil_q and reps into reps_q, set gnt one-hot, clear cnt and the period counter, and go to RUN on the next edge.
REQ-015 IDLE with req all-zero: remain in IDLE; gnt=0, cnt=0, co=0, done=0.
REQ-016 Arbitration SHALL be round-robin: search starts at the index after the last granted requester, wrapping NREQ-1 to 0; the pointer after reset is 0.
REQ-017 RUN: if cnt < ceil_q, increment cnt by 1; if cnt == ceil_q, assert co, set cnt to 0, increment the period counter.
REQ-018 RUN: when co is asserted and the period counter equals reps_q, go to DONE instead of continuing.
REQ-019 ceil_q = 0: co SHALL be high every RUN cycle, so one period lasts one cycle.
REQ-020 ceil_i and reps changes after latching SHALL NOT affect the current grant.
REQ-021 DONE lasts exactly one cycle: done[winner]=1, gnt held, cnt=0, co=0; then IDLE with gnt cleared.
REQ-022 Abort: if req[winner] is low in any RUN cycle, go to IDLE on the next edge; no done pulse; co remains combinational for that cycle; the round-robin pointer advances past the aborted requester.
REQ-023 Minimum gap between consecutive grants SHALL be one IDLE cycle after DONE.
REQ-024 Total grant length = (ceil_q+1)*(reps_q+1) RUN cycles + 1 DONE cycle.

Reset
REQ-025 rst high SHALL force IDLE, gnt=0, cnt=0, co=0, done=0, busy=0, pointer=0, ceil_q=0, reps_q=0 at the next edge.
REQ-026 rst asserted mid-RUN or in DONE SHALL abandon the grant without a done pulse; rst has priority over every other event.

Configuration
REQ-027 Macro CNT_ARB_PRIO_EN: when defined, arbitration SHALL be fixed priority (req[0] highest, req[NREQ-1] lowest) and the pointer is not implemented; when undefined, round-robin per REQ-016.

Verification
REQ-028 After reset, req=0010, ceil1=2, reps=1 -> gnt=0010 one cycle later; cnt 0,1,2,0,1,2; co on both 2s; then done=0010 for one cycle; then gnt=0000.
REQ-029 req=1111 held, all ceilings 0, reps=0 -> grants in order 0001,0010,0100,1000,0001, each RUN 1 cycle + DONE 1 cycle + IDLE 1 cycle (fixed 0001 repeatedly with CNT_ARB_PRIO_EN).
REQ-030 req=0001, ceil0=5; drop req[0] when cnt=3 -> IDLE next edge, no done pulse; next request from req=0011 is granted 0010.
REQ-031 rst raised for one cycle while cnt=4 in RUN -> next cycle gnt=0, cnt=0, busy=0, no done; pointer restarts at 0.
REQ-032 ceil2=3, reps=7 granted; change ceil_i and reps mid-RUN -> exactly 32 RUN cycles and 8 co pulses, then done=0100.
REQ-033 req=0000 for 10 cycles after reset -> gnt, done, co, busy all 0; cnt stays 0.
